// File: rtl/ysyx_lsu_pkg.sv
// ysyx_lsu_pkg: shared definitions for the load/store unit.
//   - funct3 memory-op encodings
//   - FSM state encoding
//   - op_size(): log2 of the access size in bytes, taken from funct3
package ysyx_lsu_pkg;

   localparam logic [2:0] OP_B  = 3'b000;
   localparam logic [2:0] OP_H  = 3'b001;
   localparam logic [2:0] OP_W  = 3'b010;
   localparam logic [2:0] OP_D  = 3'b011;
   localparam logic [2:0] OP_BU = 3'b100;
   localparam logic [2:0] OP_HU = 3'b101;
   localparam logic [2:0] OP_WU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   // Access size as log2(bytes): 0=b, 1=h, 2=w, 3=d. Signedness lives in op[2].
   function automatic logic [1:0] op_size(input logic [2:0] op);
      return op[1:0];
   endfunction

endpackage

// File: rtl/ysyx_lsu_fmt.sv
// ysyx_lsu_fmt: combinational data formatting for the LSU.
//   op, addr_lo    : funct3 and low three address bits
//   wdata          : low-aligned store data
//   rdata          : full aligned read word from memory
//   st_data/st_mask: store data and byte strobes shifted to their byte lane
//   ld_data        : read word shifted down, truncated and sign/zero-extended
//   misaligned     : access not naturally aligned to its size
module ysyx_lsu_fmt
   import ysyx_lsu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]        op,
   input  logic [2:0]        addr_lo,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN-1:0]   st_data,
   output logic [XLEN/8-1:0] st_mask,
   output logic [XLEN-1:0]   ld_data,
   output logic              misaligned
);

   localparam int MW    = XLEN / 8;
   localparam int OFF_W = $clog2(MW);

   logic [OFF_W-1:0] off;
   logic [OFF_W+2:0] sh_bits;
   logic [7:0]       base_mask;
   logic [XLEN-1:0]  rsh;

   assign off     = addr_lo[OFF_W-1:0];
   assign sh_bits = {off, 3'b000};

   always_comb begin
      base_mask = 8'h01;
      case (op_size(op))
         2'd0:    base_mask = 8'h01;
         2'd1:    base_mask = 8'h03;
         2'd2:    base_mask = 8'h0F;
         default: base_mask = 8'hFF;
      endcase
   end

   // With XLEN=32 the doubleword mask truncates to 0xF; that op is rejected
   // as illegal before it can reach the bus.
   assign st_mask = MW'(base_mask) << off;
   assign st_data = wdata << sh_bits;
   assign rsh     = rdata >> sh_bits;

   always_comb begin
      ld_data = rsh;
      case (op)
         OP_B:    ld_data = XLEN'($signed(rsh[7:0]));
         OP_H:    ld_data = XLEN'($signed(rsh[15:0]));
         OP_W:    ld_data = XLEN'($signed(rsh[31:0]));
         OP_BU:   ld_data = XLEN'(rsh[7:0]);
         OP_HU:   ld_data = XLEN'(rsh[15:0]);
         OP_WU:   ld_data = XLEN'(rsh[31:0]);
         default: ld_data = rsh;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (op_size(op))
         2'd1:    misaligned = addr_lo[0];
         2'd2:    misaligned = |addr_lo[1:0];
         2'd3:    misaligned = |addr_lo;
         default: misaligned = 1'b0;
      endcase
   end

endmodule

// File: rtl/ysyx_lsu.sv
// ysyx_lsu: multi-cycle load/store unit.
//   req_*      : one op at a time from EXU (valid/ready), latched in IDLE
//   mem_req_*  : request to memory, held stable until mem_req_ready
//   mem_rsp_*  : response from memory, always accepted, sampled only in WAIT
//   resp_*     : formatted result to write-back, held until resp_ready
// Illegal or misaligned ops skip memory and go straight to an error response.
// WAIT gives up after TIMEOUT cycles with resp_err set.
module ysyx_lsu
   import ysyx_lsu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic              mem_rsp_err,
   input  logic [XLEN-1:0]   mem_rsp_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_err
);

   localparam int MW = XLEN / 8;
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t            state, nxt;
   logic              we_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [4:0]        rd_q;
   logic [TW-1:0]     timer;

   logic [2:0]        op_sel, lo_sel;
   logic [XLEN-1:0]   st_data, ld_data;
   logic [MW-1:0]     st_mask;
   logic              misaligned, illegal, bad, timed_out;

   // In IDLE the formatter checks the incoming op for alignment; afterwards it
   // works from the latched op for lane shifting and load extraction.
   assign op_sel = (state == S_IDLE) ? req_op : op_q;
   assign lo_sel = (state == S_IDLE) ? req_addr[2:0] : addr_q[2:0];

   ysyx_lsu_fmt #(.XLEN(XLEN)) u_fmt (
      .op         (op_sel),
      .addr_lo    (lo_sel),
      .wdata      (wdata_q),
      .rdata      (mem_rsp_rdata),
      .st_data    (st_data),
      .st_mask    (st_mask),
      .ld_data    (ld_data),
      .misaligned (misaligned)
   );

   assign illegal = (req_op == 3'b111)
                  || (req_we && req_op[2])
                  || ((XLEN == 32) && ((req_op == OP_D) || (req_op == OP_WU)));
   assign bad       = illegal | misaligned;
   assign timed_out = (timer == TW'(TIMEOUT - 1));

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: if (req_valid) nxt = bad ? S_RESP : S_REQ;
         S_REQ:  if (mem_req_ready) nxt = S_WAIT;
         S_WAIT: if (mem_rsp_valid || timed_out) nxt = S_RESP;
         S_RESP: if (resp_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q       <= 1'b0;
         op_q       <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= 5'd0;
         timer      <= '0;
         resp_rdata <= '0;
         resp_rd    <= 5'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               we_q       <= req_we;
               op_q       <= req_op;
               addr_q     <= req_addr;
               wdata_q    <= req_wdata;
               rd_q       <= req_rd;
               resp_err   <= bad;
               resp_rdata <= '0;
               resp_rd    <= 5'd0;
            end
            S_REQ: if (mem_req_ready) timer <= '0;
            S_WAIT: begin
               timer <= timer + TW'(1);
               if (mem_rsp_valid) begin
                  resp_err <= mem_rsp_err;
                  // Stores and faulted loads return zeros with rd=0 so no
                  // register gets written.
                  if (!we_q && !mem_rsp_err) begin
                     resp_rdata <= ld_data;
                     resp_rd    <= rd_q;
                  end
               end else if (timed_out) begin
                  resp_err <= 1'b1;
               end
            end
            S_RESP: if (resp_ready) begin
               resp_rdata <= '0;
               resp_rd    <= 5'd0;
               resp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign req_ready     = (state == S_IDLE);
   assign resp_valid    = (state == S_RESP);
   assign mem_req_valid = (state == S_REQ);
   // Bus fields are driven only while a request is outstanding.
   assign mem_addr  = mem_req_valid ? (addr_q & ~ADDR_W'(MW - 1)) : '0;
   assign mem_we    = mem_req_valid & we_q;
   assign mem_wdata = mem_we ? st_data : '0;
   assign mem_wmask = mem_we ? st_mask : '0;

endmodule
